// File: rtl/ram_bist_master.sv
// Single-pass RAM BIST: writes a 2*addr pattern (optionally inverted) to every
// word, reads it back with a one-deep compare pipeline, and reports results.
module ram_bist_master #(
  parameter int ADD_SIZE    = 10,
  parameter int WORD_SIZE   = 8,
  parameter int MEMORY_SIZE = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 invert,
  output logic [ADD_SIZE-1:0]  addr,
  output logic [WORD_SIZE-1:0] data_in,
  output logic                 write_enable,
  output logic                 read_enable,
  output logic                 cs,
  input  logic [WORD_SIZE-1:0] data_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ADD_SIZE:0]    err_count,
  output logic [ADD_SIZE-1:0]  first_err_addr
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  localparam logic [ADD_SIZE-1:0] LAST    = ADD_SIZE'(MEMORY_SIZE - 1);
  localparam logic [ADD_SIZE-1:0] ADDR_ONE = ADD_SIZE'(1);
  localparam logic [ADD_SIZE:0]   ERR_ONE  = (ADD_SIZE+1)'(1);

  state_t                 state_q, state_d;
  logic [ADD_SIZE-1:0]    addr_q, addr_d;
  logic [WORD_SIZE-1:0]   data_q, data_d;
  logic                   we_q, we_d, re_q, re_d, cs_q, cs_d;
  logic                   busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [ADD_SIZE:0]      err_q, err_d;
  logic [ADD_SIZE-1:0]    first_q, first_d;
  logic                   inv_q, inv_d;
  logic                   cmp_valid_q, cmp_valid_d;
  logic [ADD_SIZE-1:0]    cmp_addr_q, cmp_addr_d;
  logic [ADD_SIZE-1:0]    addr_inc;

  // Zero-extends or truncates 2*a to the word width, then applies inversion.
  function automatic logic [WORD_SIZE-1:0] pattern(input logic [ADD_SIZE-1:0] a,
                                                   input logic inv);
    logic [WORD_SIZE+ADD_SIZE:0] wide;
    wide = '0;
    wide[ADD_SIZE:1] = a;
    return wide[WORD_SIZE-1:0] ^ {WORD_SIZE{inv}};
  endfunction

  assign addr_inc = addr_q + ADDR_ONE;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    we_d        = 1'b0;
    re_d        = 1'b0;
    cs_d        = 1'b0;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_d       = err_q;
    first_d     = first_q;
    inv_d       = inv_q;
    cmp_valid_d = 1'b0;
    cmp_addr_d  = cmp_addr_q;

    // Read data for the address issued last cycle is checked here.
    if (cmp_valid_q && (data_out != pattern(cmp_addr_q, inv_q))) begin
      err_d = err_q + ERR_ONE;
      if (err_q == '0) first_d = cmp_addr_q;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = WRITE;
          err_d   = '0;
          first_d = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          inv_d   = invert;
          addr_d  = '0;
          data_d  = pattern('0, invert);
          cs_d    = 1'b1;
          we_d    = 1'b1;
        end
      end
      WRITE: begin
        cs_d = 1'b1;
        if (addr_q == LAST) begin
          state_d = READ;
          addr_d  = '0;
          data_d  = '0;
          re_d    = 1'b1;
        end else begin
          addr_d = addr_inc;
          data_d = pattern(addr_inc, inv_q);
          we_d   = 1'b1;
        end
      end
      READ: begin
        cmp_valid_d = 1'b1;
        cmp_addr_d  = addr_q;
        if (addr_q == LAST) begin
          state_d = DRAIN;
          addr_d  = '0;
        end else begin
          cs_d   = 1'b1;
          re_d   = 1'b1;
          addr_d = addr_inc;
        end
      end
      DRAIN: begin
        // err_d already includes the final compare performed this cycle.
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_d == '0);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      cs_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      first_q     <= '0;
      inv_q       <= 1'b0;
      cmp_valid_q <= 1'b0;
      cmp_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      we_q        <= we_d;
      re_q        <= re_d;
      cs_q        <= cs_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      first_q     <= first_d;
      inv_q       <= inv_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_addr_q  <= cmp_addr_d;
    end
  end

  assign addr           = addr_q;
  assign data_in        = data_q;
  assign write_enable   = we_q;
  assign read_enable    = re_q;
  assign cs             = cs_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;

endmodule
